// File: rtl/xadac_pkg.sv
// Shared types for the XADAC accelerator port: scoreboard depth, id type and
// the payload structs of the four valid/ready channels.
package xadac_pkg;

    localparam int SbLen = 8;
    localparam int IdW   = $clog2(SbLen);
    localparam int XLen  = 32;

    typedef logic [IdW-1:0] id_t;

    typedef struct packed {
        id_t             id;
        logic [XLen-1:0] instr;
    } dec_req_t;

    typedef struct packed {
        id_t  id;
        logic accept;
    } dec_rsp_t;

    typedef struct packed {
        id_t             id;
        logic [XLen-1:0] opa;
    } exe_req_t;

    typedef struct packed {
        id_t             id;
        logic [XLen-1:0] res;
    } exe_rsp_t;

endpackage

// File: rtl/xadac_if.sv
// XADAC channel bundle: dec_req/dec_rsp/exe_req/exe_rsp, each valid/ready.
interface xadac_if;
    import xadac_pkg::*;

    dec_req_t dec_req;
    logic     dec_req_valid;
    logic     dec_req_ready;
    dec_rsp_t dec_rsp;
    logic     dec_rsp_valid;
    logic     dec_rsp_ready;
    exe_req_t exe_req;
    logic     exe_req_valid;
    logic     exe_req_ready;
    exe_rsp_t exe_rsp;
    logic     exe_rsp_valid;
    logic     exe_rsp_ready;

    modport slv (
        input  dec_req, dec_req_valid, dec_rsp_ready,
        input  exe_req, exe_req_valid, exe_rsp_ready,
        output dec_req_ready, dec_rsp, dec_rsp_valid,
        output exe_req_ready, exe_rsp, exe_rsp_valid
    );

    modport mst (
        output dec_req, dec_req_valid, dec_rsp_ready,
        output exe_req, exe_req_valid, exe_rsp_ready,
        input  dec_req_ready, dec_rsp, dec_rsp_valid,
        input  exe_req_ready, exe_rsp, exe_rsp_valid
    );

endinterface

// File: rtl/xadac_rr_arb.sv
// N-way round-robin arbiter; a grant that is not accepted is locked until
// its handshake, so the chosen requester cannot be pre-empted mid-transfer.
module xadac_rr_arb #(
    parameter  int N    = 2,
    localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N-1:0]    req,
    input  logic            ready,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] gnt_idx
);

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic            lock_q, lock_d;
    logic [IdxW-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        if (lock_q) begin
            gnt[lock_idx_q] = req[lock_idx_q];
            gnt_idx         = lock_idx_q;
        end else begin
            // walk from lowest priority to highest so the last hit wins
            for (int k = N - 1; k >= 0; k--) begin
                cand = IdxW'((int'(ptr_q) + k) % N);
                if (req[cand]) begin
                    gnt       = '0;
                    gnt[cand] = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (|gnt) begin
            if (ready) begin
                lock_d = 1'b0;
                ptr_d  = (gnt_idx == IdxW'(N - 1)) ? '0 : gnt_idx + IdxW'(1);
            end else begin
                lock_d     = 1'b1;
                lock_idx_d = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: rtl/xadac_arb.sv
// Shares one XADAC master port among NoSlv requesters. Channels pass through
// combinationally; only the id scoreboard (busy/owner) and arbiters are registered.
module xadac_arb
    import xadac_pkg::*;
#(
    parameter int NoSlv = 2
) (
    input logic  clk,
    input logic  rstn,
    xadac_if.slv slv [NoSlv],
    xadac_if.mst mst
);

    localparam int OwnW = (NoSlv > 1) ? $clog2(NoSlv) : 1;
    typedef logic [OwnW-1:0] own_t;

    logic [SbLen-1:0]       busy_q, busy_d;
    own_t [SbLen-1:0]       owner_q, owner_d;

    dec_req_t               dec_req_in [NoSlv];
    exe_req_t               exe_req_in [NoSlv];
    logic [NoSlv-1:0]       dec_elig, exe_elig, dec_gnt, exe_gnt;
    logic [NoSlv-1:0]       dec_rsp_sel, exe_rsp_sel, dec_rsp_rdy, exe_rsp_rdy;
    own_t                   dec_idx, exe_idx;
    dec_req_t               dec_req_mux;
    exe_req_t               exe_req_mux;
    logic                   dec_hs, exe_rsp_hs, dec_rsp_live, exe_rsp_live;
    logic                   stray_rsp;

    logic                   dec_hold_q, dec_hold_d, exe_hold_q, exe_hold_d;
    dec_req_t               dec_prev_q, dec_prev_d;
    exe_req_t               exe_prev_q, exe_prev_d;

    // responses are only routed for ids with a live owner
    assign dec_rsp_live = rstn && busy_q[mst.dec_rsp.id];
    assign exe_rsp_live = rstn && busy_q[mst.exe_rsp.id];

    for (genvar g = 0; g < NoSlv; g++) begin : g_slv
        assign dec_req_in[g]  = slv[g].dec_req;
        assign exe_req_in[g]  = slv[g].exe_req;
        assign dec_rsp_rdy[g] = slv[g].dec_rsp_ready;
        assign exe_rsp_rdy[g] = slv[g].exe_rsp_ready;

        assign dec_elig[g] = rstn && slv[g].dec_req_valid && !busy_q[slv[g].dec_req.id];
        assign exe_elig[g] = rstn && slv[g].exe_req_valid && busy_q[slv[g].exe_req.id]
                             && (owner_q[slv[g].exe_req.id] == own_t'(g));

        assign dec_rsp_sel[g] = dec_rsp_live && (owner_q[mst.dec_rsp.id] == own_t'(g));
        assign exe_rsp_sel[g] = exe_rsp_live && (owner_q[mst.exe_rsp.id] == own_t'(g));

        assign slv[g].dec_req_ready = dec_gnt[g] && mst.dec_req_ready;
        assign slv[g].exe_req_ready = exe_gnt[g] && mst.exe_req_ready;
        assign slv[g].dec_rsp       = mst.dec_rsp;
        assign slv[g].dec_rsp_valid = dec_rsp_sel[g] && mst.dec_rsp_valid;
        assign slv[g].exe_rsp       = mst.exe_rsp;
        assign slv[g].exe_rsp_valid = exe_rsp_sel[g] && mst.exe_rsp_valid;
    end

    xadac_rr_arb #(.N(NoSlv)) u_dec_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     (dec_elig),
        .ready   (mst.dec_req_ready),
        .gnt     (dec_gnt),
        .gnt_idx (dec_idx)
    );

    xadac_rr_arb #(.N(NoSlv)) u_exe_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     (exe_elig),
        .ready   (mst.exe_req_ready),
        .gnt     (exe_gnt),
        .gnt_idx (exe_idx)
    );

    always_comb begin
        dec_req_mux = '0;
        exe_req_mux = '0;
        for (int i = 0; i < NoSlv; i++) begin
            if (dec_gnt[i]) dec_req_mux = dec_req_in[i];
            if (exe_gnt[i]) exe_req_mux = exe_req_in[i];
        end
    end

    assign mst.dec_req       = dec_req_mux;
    assign mst.dec_req_valid = |dec_gnt;
    assign mst.exe_req       = exe_req_mux;
    assign mst.exe_req_valid = |exe_gnt;
    assign mst.dec_rsp_ready = |(dec_rsp_sel & dec_rsp_rdy);
    assign mst.exe_rsp_ready = |(exe_rsp_sel & exe_rsp_rdy);

    assign dec_hs     = (|dec_gnt) && mst.dec_req_ready;
    assign exe_rsp_hs = mst.exe_rsp_valid && (|(exe_rsp_sel & exe_rsp_rdy));

    // set and clear never collide: a busy id is never eligible for dec_req
    always_comb begin
        busy_d  = busy_q;
        owner_d = owner_q;
        if (exe_rsp_hs) busy_d[mst.exe_rsp.id] = 1'b0;
        if (dec_hs) begin
            busy_d[dec_req_mux.id]  = 1'b1;
            owner_d[dec_req_mux.id] = dec_idx;
        end
    end

    assign stray_rsp = rstn && ((mst.dec_rsp_valid && !busy_q[mst.dec_rsp.id]) ||
                                (mst.exe_rsp_valid && !busy_q[mst.exe_rsp.id]));

    assign dec_hold_d = (|dec_gnt) && !mst.dec_req_ready;
    assign exe_hold_d = (|exe_gnt) && !mst.exe_req_ready;
    assign dec_prev_d = dec_req_mux;
    assign exe_prev_d = exe_req_mux;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q     <= '0;
            owner_q    <= '0;
            dec_hold_q <= 1'b0;
            exe_hold_q <= 1'b0;
            dec_prev_q <= '0;
            exe_prev_q <= '0;
        end else begin
            busy_q     <= busy_d;
            owner_q    <= owner_d;
            dec_hold_q <= dec_hold_d;
            exe_hold_q <= exe_hold_d;
            dec_prev_q <= dec_prev_d;
            exe_prev_q <= exe_prev_d;
        end
    end

    always @(posedge clk) begin
        if (rstn) begin
            assert (!stray_rsp)
                else $error("xadac_arb: response for an id that is not busy");
            assert (!dec_hold_q || dec_req_mux == dec_prev_q)
                else $error("xadac_arb: dec_req payload changed while stalled");
            assert (!exe_hold_q || exe_req_mux == exe_prev_q)
                else $error("xadac_arb: exe_req payload changed while stalled");
            assert (!(|exe_gnt) || owner_q[exe_req_mux.id] == exe_idx)
                else $error("xadac_arb: exe_req granted to a non-owner");
        end
    end

endmodule

// File: tb/tb_xadac_arb.sv
// Directed bench for xadac_arb with two requesters: arbitration, lock, id
// scoreboard, response routing and reset behaviour.
module tb_xadac_arb;
    import xadac_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    xadac_if slv_if [2] ();
    xadac_if mst_if ();

    logic [1:0]  dv, ev, drr, err;
    id_t         did [2];
    id_t         eid [2];
    logic [31:0] dins [2];
    logic        m_drdy, m_erdy, m_drsp_v, m_ersp_v;
    id_t         m_drsp_id, m_ersp_id;
    logic [1:0]  s_drdy, s_erdy, s_drsp_v, s_ersp_v;

    int passed = 0;
    int total  = 0;

    for (genvar g = 0; g < 2; g++) begin : g_tb
        assign slv_if[g].dec_req       = '{id: did[g], instr: dins[g]};
        assign slv_if[g].dec_req_valid = dv[g];
        assign slv_if[g].exe_req       = '{id: eid[g], opa: dins[g]};
        assign slv_if[g].exe_req_valid = ev[g];
        assign slv_if[g].dec_rsp_ready = drr[g];
        assign slv_if[g].exe_rsp_ready = err[g];
        assign s_drdy[g]   = slv_if[g].dec_req_ready;
        assign s_erdy[g]   = slv_if[g].exe_req_ready;
        assign s_drsp_v[g] = slv_if[g].dec_rsp_valid;
        assign s_ersp_v[g] = slv_if[g].exe_rsp_valid;
    end

    assign mst_if.dec_req_ready = m_drdy;
    assign mst_if.exe_req_ready = m_erdy;
    assign mst_if.dec_rsp       = '{id: m_drsp_id, accept: 1'b1};
    assign mst_if.dec_rsp_valid = m_drsp_v;
    assign mst_if.exe_rsp       = '{id: m_ersp_id, res: 32'h5A5A_0000};
    assign mst_if.exe_rsp_valid = m_ersp_v;

    xadac_arb #(.NoSlv(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .slv  (slv_if),
        .mst  (mst_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        dv = '0; ev = '0; drr = 2'b11; err = 2'b11;
        did[0] = '0; did[1] = '0; eid[0] = '0; eid[1] = '0;
        dins[0] = 32'hA000_0000; dins[1] = 32'hB000_0001;
        m_drdy = 1'b0; m_erdy = 1'b0; m_drsp_v = 1'b0; m_ersp_v = 1'b0;
        m_drsp_id = '0; m_ersp_id = '0;

        // requests and a response presented while in reset
        #2;
        dv = 2'b11; m_drdy = 1'b1; m_ersp_v = 1'b1;
        #1;
        chk("rst_mst_dec_valid", 32'(mst_if.dec_req_valid), 32'd0);
        chk("rst_slv_dec_ready", 32'(s_drdy), 32'd0);
        chk("rst_slv_exe_rsp_v", 32'(s_ersp_v), 32'd0);
        chk("rst_mst_exe_rsp_rdy", 32'(mst_if.exe_rsp_ready), 32'd0);
        chk("rst_busy", 32'(dut.busy_q), 32'd0);
        chk("rst_dec_ptr", 32'(dut.u_dec_arb.ptr_q), 32'd0);
        dv = '0; m_ersp_v = 1'b0;
        step();
        rstn = 1'b1;

        // alternating grants, ids 0..3
        did[0] = 3'd0; did[1] = 3'd1; dv = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("rr_id", 32'(mst_if.dec_req.id), 32'(c));
            chk("rr_ready", 32'(s_drdy), (c % 2 == 0) ? 32'd1 : 32'd2);
            step();
            did[c % 2] = did[c % 2] + 3'd2;
        end
        dv = '0;
        #1;
        chk("rr_busy", 32'(dut.busy_q), 32'h0F);
        chk("rr_ptr_wrap", 32'(dut.u_dec_arb.ptr_q), 32'd0);

        // release ids 0..3 through exe_rsp
        for (int k = 0; k < 4; k++) begin
            m_ersp_v = 1'b1; m_ersp_id = id_t'(k);
            #1;
            chk("rel_route", 32'(s_ersp_v), (k % 2 == 0) ? 32'd1 : 32'd2);
            step();
            chk("rel_busy", 32'(dut.busy_q), 32'h0F & ~((32'd2 << k) - 32'd1));
        end
        m_ersp_v = 1'b0;

        // slave 0 takes id 3, slave 1 takes id 5
        did[0] = 3'd3; did[1] = 3'd5; dv = 2'b11;
        #1;
        chk("own_gnt0", 32'(s_drdy), 32'd1);
        step();
        dv[0] = 1'b0;
        #1;
        chk("own_gnt1", 32'(s_drdy), 32'd2);
        chk("own_id1", 32'(mst_if.dec_req.id), 32'd5);
        step();
        dv = '0;
        #1;
        chk("own_busy", 32'(dut.busy_q), 32'h28);
        m_drsp_v = 1'b1; m_drsp_id = 3'd5;
        #1;
        chk("dec_rsp_5", 32'(s_drsp_v), 32'd2);
        m_drsp_id = 3'd3;
        #1;
        chk("dec_rsp_3", 32'(s_drsp_v), 32'd1);
        m_drsp_v = 1'b0;
        ev[1] = 1'b1; eid[1] = 3'd3; m_erdy = 1'b1;
        #1;
        chk("exe_nonowner_rdy", 32'(s_erdy), 32'd0);
        chk("exe_nonowner_v", 32'(mst_if.exe_req_valid), 32'd0);
        ev[0] = 1'b1; eid[0] = 3'd3;
        #1;
        chk("exe_owner_rdy", 32'(s_erdy), 32'd1);
        ev = '0;
        m_ersp_v = 1'b1; m_ersp_id = 3'd5;
        #1;
        chk("exe_rsp_5", 32'(s_ersp_v), 32'd2);
        step();
        chk("busy_after_5", 32'(dut.busy_q), 32'h08);
        m_ersp_id = 3'd3;
        #1;
        chk("exe_rsp_3", 32'(s_ersp_v), 32'd1);
        step();
        m_ersp_v = 1'b0;
        chk("busy_after_3", 32'(dut.busy_q), 32'h00);

        // lock: slave 1 stalled 3 cycles while slave 0 raises valid
        m_drdy = 1'b0; did[1] = 3'd1; dv = 2'b10;
        #1;
        chk("lock_c1_id", 32'(mst_if.dec_req.id), 32'd1);
        chk("lock_c1_rdy", 32'(s_drdy), 32'd0);
        step();
        did[0] = 3'd0; dv = 2'b11;
        #1;
        chk("lock_c2_id", 32'(mst_if.dec_req.id), 32'd1);
        step();
        #1;
        chk("lock_c3_id", 32'(mst_if.dec_req.id), 32'd1);
        step();
        m_drdy = 1'b1;
        #1;
        chk("lock_hs_rdy", 32'(s_drdy), 32'd2);
        step();
        dv[1] = 1'b0;
        #1;
        chk("lock_next_rdy", 32'(s_drdy), 32'd1);
        chk("lock_next_id", 32'(mst_if.dec_req.id), 32'd0);
        step();
        dv = '0;
        #1;
        chk("lock_ptr", 32'(dut.u_dec_arb.ptr_q), 32'd1);

        // id 0 owned by slave 0; slave 1 asks for id 0
        did[1] = 3'd0; dv = 2'b10;
        #1;
        chk("busy_stall", 32'(s_drdy), 32'd0);
        step();
        m_ersp_v = 1'b1; m_ersp_id = 3'd0;
        #1;
        chk("busy_stall_rel_cyc", 32'(s_drdy), 32'd0);
        chk("busy_rel_route", 32'(s_ersp_v), 32'd1);
        step();
        m_ersp_v = 1'b0;
        #1;
        chk("busy_reuse", 32'(s_drdy), 32'd2);
        step();
        dv = '0;

        // fill the scoreboard from slave 0
        for (int k = 2; k < 8; k++) begin
            did[0] = id_t'(k); dv = 2'b01;
            step();
        end
        dv = '0;
        #1;
        chk("full_busy", 32'(dut.busy_q), 32'hFF);
        did[0] = 3'd3; did[1] = 3'd4; dv = 2'b11;
        #1;
        chk("full_no_rdy", 32'(s_drdy), 32'd0);
        chk("full_no_valid", 32'(mst_if.dec_req_valid), 32'd0);
        step();
        m_ersp_v = 1'b1; m_ersp_id = 3'd4;
        step();
        m_ersp_v = 1'b0;
        #1;
        chk("full_one_gnt", 32'(s_drdy), 32'd2);
        chk("full_one_id", 32'(mst_if.dec_req.id), 32'd4);
        step();
        #1;
        chk("full_again", 32'(s_drdy), 32'd0);
        dv = '0;
        ev[0] = 1'b1; eid[0] = 3'd2;
        step();
        ev = '0;
        #1;
        chk("exe_ptr_adv", 32'(dut.u_exe_arb.ptr_q), 32'd1);

        // reset with ids in flight
        rstn = 1'b0;
        dv = 2'b11; ev = 2'b11; eid[0] = 3'd2; eid[1] = 3'd4;
        m_ersp_v = 1'b1; m_ersp_id = 3'd4;
        #1;
        chk("mid_rst_dec_v", 32'(mst_if.dec_req_valid), 32'd0);
        chk("mid_rst_exe_v", 32'(mst_if.exe_req_valid), 32'd0);
        chk("mid_rst_dec_rdy", 32'(s_drdy), 32'd0);
        chk("mid_rst_rsp_v", 32'(s_ersp_v), 32'd0);
        chk("mid_rst_busy", 32'(dut.busy_q), 32'd0);
        chk("mid_rst_dec_ptr", 32'(dut.u_dec_arb.ptr_q), 32'd0);
        chk("mid_rst_exe_ptr", 32'(dut.u_exe_arb.ptr_q), 32'd0);
        dv = '0; ev = '0; m_ersp_v = 1'b0;
        step();
        rstn = 1'b1;
        #1;
        // stray response is withdrawn before the next edge
        m_ersp_v = 1'b1; m_ersp_id = 3'd4;
        #1;
        chk("stray_route", 32'(s_ersp_v), 32'd0);
        chk("stray_rdy", 32'(mst_if.exe_rsp_ready), 32'd0);
        chk("stray_flag", 32'(dut.stray_rsp), 32'd1);
        m_ersp_v = 1'b0;
        step();
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/xadac_arb.md
XADAC_ARB -- requirements
Module: xadac_arb

Interface
REQ-001 SHALL have parameter NoSlv, default 2, meaning the number of requester ports (>=2).
REQ-002 SHALL have input clk, 1 bit: the single clock.
REQ-003 SHALL have input rstn, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port slv, xadac_if.slv array [NoSlv]: requester-side ports, each carrying dec_req/dec_rsp/exe_req/exe_rsp valid-ready channels.
REQ-005 SHALL have port mst, xadac_if.mst: a single port toward the shared accelerator.

Function
REQ-006 SHALL share one mst port among NoSlv requesters; every channel is combinational pass-through (0-cycle latency), and only bookkeeping is registered.
REQ-007 dec_req arbitration SHALL be round-robin.
  - Eligible: slv[i].dec_req_valid && !busy_q[slv[i].dec_req.id].
  - Priority starts at dec_ptr_q.
REQ-008 dec_req grant SHALL be locked.
  - Lock is set when a valid is forwarded and mst.dec_req_ready=0.
  - Grant is held on the same slave until handshake; the lock ignores newly eligible higher-priority slaves.
REQ-009 The granted slave SHALL be forwarded to mst.dec_req/valid, and mst.dec_req_ready SHALL be returned only to that slave; all other slv dec_req_ready=0.
REQ-010 On dec_req handshake with id k from slave i, the block SHALL do all of the following.
  - Set busy_d[k]=1 and owner_d[k]=i.
  - Set dec_ptr_d=(i+1) mod NoSlv and clear the lock.
REQ-011 mst.dec_rsp SHALL be routed to slv[owner_q[mst.dec_rsp.id]].
  - That slave's dec_rsp_ready is returned to mst.
  - Other slaves see dec_rsp_valid=0.
REQ-012 exe_req arbitration SHALL be a second independent round-robin arbiter with lock (exe_ptr_q), per REQ-007/008.
  - Eligibility is slv[i].exe_req_valid && busy_q[id] && owner_q[id]==i.
  - A non-owned exe_req is never granted and gets ready=0.
REQ-013 mst.exe_rsp SHALL be routed by owner_q[mst.exe_rsp.id].
  - On its handshake, busy_d[id]=0.
REQ-014 busy_q SHALL gate eligibility, which has the following consequences.
  - An id released in cycle t is reusable from cycle t+1.
  - A same-cycle set and clear can never target the same id.
REQ-015 When all SbLen ids are busy, no dec_req SHALL be granted; requests stall without loss.
REQ-016 Pointer wrap: ptr==NoSlv-1 SHALL advance to 0.
REQ-017 When no valid requests are present, pointers and locks SHALL hold.
REQ-018 Simultaneous handshakes on all four channels in one cycle SHALL be supported.

Reset
REQ-019 On rstn=0, regardless of clk, the following SHALL be cleared.
  - busy_q, owner_q, dec_ptr_q, exe_ptr_q and both locks cleared to 0.
  - All valid outputs (mst.dec_req_valid, mst.exe_req_valid, slv[*].dec_rsp_valid, slv[*].exe_rsp_valid) = 0.
  - All ready outputs = 0.
REQ-020 Reset mid-transaction SHALL discard all in-flight ownership.
  - No response SHALL be routed until a new dec_req handshake.

Structure
REQ-021 SbLen and the id type SHALL come from xadac_pkg; an owner index type SHALL NOT be added to the package (it is local, $clog2(NoSlv) bits).
REQ-022 A sub-module xadac_rr_arb (N-way round-robin with lock, req/gnt one-hot, ptr register) SHALL be instantiated twice, once for dec_req and once for exe_req.
REQ-023 Assertions SHALL flag:
  - a response id with busy_q=0;
  - a granted request whose payload changes while valid && !ready.

Verification
REQ-024 Slaves 0 and 1 both issue dec_req continuously with distinct ids, mst ready=1 -> grants alternate 0,1,0,1; each gets one handshake per 2 cycles.
REQ-025 Slave 1 is granted with mst.dec_req_ready=0 for 3 cycles while slave 0 raises valid -> grant stays on 1 until its handshake, then slave 0 is granted the next cycle.
REQ-026 Slave 0 decodes id 3, slave 1 decodes id 5; mst returns exe_rsp for id 5, then id 3 -> each response reaches only its owner; busy[5] and busy[3] clear one cycle after their handshakes.
REQ-027 With id 2 busy (owned by slave 0) and slave 1 issuing dec_req id 2 -> slave 1 is stalled until exe_rsp id 2 handshakes, then granted the following cycle.
REQ-028 All SbLen ids are busy -> no dec_req_ready to any slave; freeing one id -> exactly one grant.
REQ-029 Assert rstn=0 with 2 ids busy, then release -> all valids and readies are 0, pointers are 0, and a stray exe_rsp id fires the assertion.
